// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: control word, queue entry and the MIPS decoder helper functions.
package signals;
  localparam int XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
                         OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e,
                         OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_ADD = 6'h20,
                         F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2a,
                         F_SLTU = 6'h2b;

  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR} pc_src_t;
  typedef enum logic [1:0] {DEST_RT, DEST_RD, DEST_RA} dest_t;
  typedef enum logic {SA, RS} sa_src_t;
  typedef enum logic {B_REG, B_IMM} alu_b_t;
  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
                            ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI} alu_op_t;

  typedef struct packed {
    pc_src_t pc_src;
    dest_t   dest_reg;
    logic    write_reg;
    sa_src_t alu_srcSa;
    alu_b_t  alu_srcB;
    alu_op_t alu_op;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    sign_ext;
  } control_t;

  // All-zero control: sequential PC, no register write, no memory access.
  localparam control_t CTL_CLEARED = '0;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    control_t        ctl;
    logic            ri;
  } entry_t;

  function automatic logic funct_known(input logic [5:0] f);
    case (f)
      F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JR, F_ADD, F_ADDU, F_SUB, F_SUBU,
      F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic control_t rtype_ctl(input logic [5:0] f);
    control_t c;
    c = CTL_CLEARED;
    c.dest_reg  = DEST_RD;
    c.write_reg = 1'b1;
    case (f)
      F_SLL:         c.alu_op = ALU_SLL;
      F_SRL:         c.alu_op = ALU_SRL;
      F_SRA:         c.alu_op = ALU_SRA;
      F_SLLV:        begin c.alu_op = ALU_SLL; c.alu_srcSa = RS; end
      F_SRLV:        begin c.alu_op = ALU_SRL; c.alu_srcSa = RS; end
      F_SRAV:        begin c.alu_op = ALU_SRA; c.alu_srcSa = RS; end
      F_JR:          begin c.write_reg = 1'b0; c.pc_src = PC_JR; end
      F_ADD, F_ADDU: c.alu_op = ALU_ADD;
      F_SUB, F_SUBU: c.alu_op = ALU_SUB;
      F_AND:         c.alu_op = ALU_AND;
      F_OR:          c.alu_op = ALU_OR;
      F_XOR:         c.alu_op = ALU_XOR;
      F_NOR:         c.alu_op = ALU_NOR;
      F_SLT:         c.alu_op = ALU_SLT;
      F_SLTU:        c.alu_op = ALU_SLTU;
      default:       c = CTL_CLEARED;
    endcase
    return c;
  endfunction

  function automatic control_t itype_ctl(input logic [5:0] op);
    control_t c;
    c = CTL_CLEARED;
    c.dest_reg  = DEST_RT;
    c.write_reg = 1'b1;
    c.alu_srcB  = B_IMM;
    c.sign_ext  = 1'b1;
    case (op)
      OP_J:              begin c.write_reg = 1'b0; c.pc_src = PC_JUMP; end
      OP_JAL:            begin c.dest_reg = DEST_RA; c.pc_src = PC_JUMP; end
      OP_BEQ, OP_BNE:    begin
        c.write_reg = 1'b0; c.alu_srcB = B_REG; c.alu_op = ALU_SUB; c.pc_src = PC_BRANCH;
      end
      OP_ADDI, OP_ADDIU: c.alu_op = ALU_ADD;
      OP_SLTI:           c.alu_op = ALU_SLT;
      OP_SLTIU:          c.alu_op = ALU_SLTU;
      OP_ANDI:           begin c.alu_op = ALU_AND; c.sign_ext = 1'b0; end
      OP_ORI:            begin c.alu_op = ALU_OR;  c.sign_ext = 1'b0; end
      OP_XORI:           begin c.alu_op = ALU_XOR; c.sign_ext = 1'b0; end
      OP_LUI:            c.alu_op = ALU_LUI;
      OP_LW:             begin c.alu_op = ALU_ADD; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; end
      OP_SW:             begin c.write_reg = 1'b0; c.mem_write = 1'b1; c.alu_op = ALU_ADD; end
      default:           c = CTL_CLEARED;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/decode_queue_instr_decoder.sv
// Combinational MIPS decode: control word plus reserved-instruction flag.
module instr_decoder
  import signals::*;
(
  input  logic [31:0] instr,
  output control_t    ctl,
  output logic        ri
);
  logic [5:0] op, funct;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    ri  = (op == OP_RTYPE) ? !funct_known(funct) : !op_known(op);
    ctl = CTL_CLEARED;
    if (!ri) ctl = (op == OP_RTYPE) ? rtype_ctl(funct) : itype_ctl(op);
  end
endmodule

// File: rtl/decode_queue.sv
// Decode-at-enqueue instruction queue between fetch and execute.
// Entry width comes from signals::XLEN, so XLEN must match it.
module decode_queue
  import signals::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_instr,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_instr,
  output logic [XLEN-1:0]        out_pc,
  output control_t               out_ctl,
  output logic                   out_ri,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  control_t        dec_ctl;
  logic            dec_ri;
  logic            enq, deq;

  instr_decoder u_dec (.instr(in_instr[31:0]), .ctl(dec_ctl), .ri(dec_ri));

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count != ($clog2(DEPTH)+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{instr: in_instr, pc: in_pc, ctl: dec_ctl, ri: dec_ri};
  end

  assign head      = mem[rd_ptr];
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_ctl   = out_valid ? head.ctl   : CTL_CLEARED;
  assign out_ri    = out_valid ? head.ri    : 1'b0;
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, meaning instruction/PC width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning reset; it is synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  meaning fetch offers an instruction.
REQ-006 SHALL have port in_ready  output  1  meaning the queue accepts this cycle; equals not-full, with no combinational path from out_ready.
REQ-007 SHALL have port in_instr  input  XLEN  meaning the raw instruction word.
REQ-008 SHALL have port in_pc  input  XLEN  meaning the PC of in_instr.
REQ-009 SHALL have port flush  input  1  meaning discard all entries (branch/exception redirect).
REQ-010 SHALL have port out_valid  output  1  meaning the head entry is valid.
REQ-011 SHALL have port out_ready  input  1  meaning the execute stage consumes the head.
REQ-012 SHALL have port out_instr  output  XLEN  meaning the head raw instruction.
REQ-013 SHALL have port out_pc  output  XLEN  meaning the head PC.
REQ-014 SHALL have port out_ctl  output  signals::control_t  meaning the decoded control of the head.
REQ-015 SHALL have port out_ri  output  1  meaning the head opcode/funct is reserved (illegal).
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  meaning current occupancy.

Function
REQ-017 Enqueue SHALL occur when in_valid && in_ready && !flush; decode SHALL happen at enqueue and the control word SHALL be stored with the entry.
REQ-018 Latency SHALL be one cycle: an entry enqueued in cycle N is visible at the head (if queue was empty) with out_valid=1 in cycle N+1.
REQ-019 Dequeue SHALL occur when out_valid && out_ready && !flush; head advances in the same edge.
REQ-020 Simultaneous enqueue and dequeue SHALL keep count unchanged; allowed at any occupancy below DEPTH.
REQ-021 When count==DEPTH, in_ready SHALL be 0 even if out_ready=1; in_valid is ignored.
REQ-022 When count==0, out_valid SHALL be 0 and out_ready is ignored; out_* data SHALL be the cleared control and zeros.
REQ-023 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count distinguishes full from empty.
REQ-024 flush SHALL take priority over enqueue and dequeue: next cycle count=0, out_valid=0, pointers=0; a concurrent in_valid is dropped.
REQ-025 Held head data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Reserved encodings SHALL enqueue with out_ri=1 and the cleared control word (no register write, no branch).
REQ-027 Decode of a shift with register amount SHALL select the RS shift-amount source; immediate shift SHALL select SA.

Reset
REQ-028 With reset_n=0 at a rising edge, count=0, pointers=0, out_valid=0, in_ready=1 (after the edge), out_ri=0, out_ctl=cleared control.
REQ-029 Reset mid-operation SHALL discard all entries; reset dominates flush and handshakes.
REQ-030 Storage RAM contents need not be reset; only valid-tracking state.

Structure
REQ-031 Entry typedef (instr, pc, control_t, ri) SHALL live in a shared package alongside signals; no new constants elsewhere.
REQ-032 Combinational decode SHALL be one sub-module instr_decoder (instr in; control_t and ri out), built from the existing decoder helper functions.
REQ-033 Queue storage SHALL be a DEPTH-entry register array inside decode_queue.

Verification
REQ-034 Reset then enqueue ADDU $3,$1,$2 (0x00221821) at PC 0x400 -> next cycle out_valid=1, out_pc=0x400, dest_reg=RD, write_reg=1, count=1.
REQ-035 DEPTH=4, enqueue 5 with out_ready=0 -> in_ready=0 after 4th, count=4, 5th dropped; drain yields the first 4 in order.
REQ-036 count=2, in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, FIFO order preserved across pointer wrap.
REQ-037 count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, nothing dequeued or enqueued.
REQ-038 Enqueue 0xFC000000 (reserved opcode) -> out_ri=1, write_reg=0, pc_src not branch.
REQ-039 Enqueue SLLV then SLL -> first head alu_srcSa=RS, second head alu_srcSa=SA; reset_n=0 mid-stream -> count=0 next cycle.
